// File: rtl/trap_arbiter.sv
// Trap arbiter: picks one exception or interrupt per trap, registers its payload,
// pulses trap_valid, then holds a full flush until the trap vector redirect arrives.
module trap_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_exc_valid,
  input  logic [4:0]  if_exc_cause,
  input  logic [31:0] if_exc_pc,
  input  logic [31:0] if_exc_va,
  input  logic        ex_exc_valid,
  input  logic [4:0]  ex_exc_cause,
  input  logic [31:0] ex_exc_pc,
  input  logic [31:0] ex_exc_inst,
  input  logic        mem_exc_valid,
  input  logic [4:0]  mem_exc_cause,
  input  logic [31:0] mem_exc_pc,
  input  logic [31:0] mem_exc_va,
  input  logic [31:0] mem_exc_inst,
  input  logic [2:0]  irq_pending,
  input  logic        pipe_stall,
  input  logic        csr_branch_signal,
  output logic        trap_valid,
  output logic [4:0]  trap_id,
  output logic [31:0] trap_pc,
  output logic [31:0] trap_inst,
  output logic [31:0] trap_va_imem,
  output logic [31:0] trap_va_dmem,
  output logic [1:0]  flush,
  output logic        busy,
  output logic        trap_err,
  output logic [15:0] trap_count
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    TRAP       = 2'd1,
    WAIT_REDIR = 2'd2
  } state_e;

  typedef struct packed {
    logic [4:0]  id;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] va_imem;
    logic [31:0] va_dmem;
  } payload_t;

  localparam logic [3:0] IRQ_CODE_EXT   = 4'd11;
  localparam logic [3:0] IRQ_CODE_SOFT  = 4'd3;
  localparam logic [3:0] IRQ_CODE_TIMER = 4'd7;

  state_e   state_q, state_d;
  payload_t winner;
  payload_t payload_q;
  logic     winner_found;
  logic     irq_eligible;
  logic [2:0] tmo_q;
  logic     timeout;

  // Only bits [3:0] of a cause reach trap_id; bit 4 is deliberately dropped.
  logic unused_cause_bits;
  assign unused_cause_bits = ^{if_exc_cause[4], ex_exc_cause[4], mem_exc_cause[4]};

  assign irq_eligible = !if_exc_valid && !ex_exc_valid && !mem_exc_valid && !pipe_stall;

  // NOTE: every variable written in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    if (mem_exc_valid) begin
      winner_found   = 1'b1;
      winner.id      = {1'b0, mem_exc_cause[3:0]};
      winner.pc      = mem_exc_pc;
      winner.inst    = mem_exc_inst;
      winner.va_dmem = mem_exc_va;
    end else if (ex_exc_valid) begin
      winner_found = 1'b1;
      winner.id    = {1'b0, ex_exc_cause[3:0]};
      winner.pc    = ex_exc_pc;
      winner.inst  = ex_exc_inst;
    end else if (if_exc_valid) begin
      winner_found   = 1'b1;
      winner.id      = {1'b0, if_exc_cause[3:0]};
      winner.pc      = if_exc_pc;
      winner.va_imem = if_exc_va;
    end else if (irq_eligible && (irq_pending != 3'b000)) begin
      winner_found = 1'b1;
      winner.pc    = if_exc_pc;
      if (irq_pending[2])      winner.id = {1'b1, IRQ_CODE_EXT};
      else if (irq_pending[1]) winner.id = {1'b1, IRQ_CODE_SOFT};
      else                     winner.id = {1'b1, IRQ_CODE_TIMER};
    end
  end

  // The redirect wins over a timeout landing on the same cycle.
  assign timeout = (state_q == WAIT_REDIR) && !csr_branch_signal && (tmo_q == 3'd7);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (winner_found) state_d = TRAP;
      TRAP:       state_d = WAIT_REDIR;
      WAIT_REDIR: if (csr_branch_signal || timeout) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      payload_q  <= '0;
      tmo_q      <= 3'd0;
      trap_err   <= 1'b0;
      trap_count <= 16'd0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && winner_found) payload_q <= winner;
      if (state_q == TRAP) tmo_q <= 3'd0;
      else if (state_q == WAIT_REDIR) tmo_q <= tmo_q + 3'd1;
      if (timeout) trap_err <= 1'b1;
      if (state_q == TRAP && trap_count != 16'hFFFF) trap_count <= trap_count + 16'd1;
    end
  end

  assign trap_valid   = (state_q == TRAP);
  assign busy         = (state_q != IDLE);
  assign flush        = busy ? 2'b11 : 2'b00;
  assign trap_id      = payload_q.id;
  assign trap_pc      = payload_q.pc;
  assign trap_inst    = payload_q.inst;
  assign trap_va_imem = payload_q.va_imem;
  assign trap_va_dmem = payload_q.va_dmem;

endmodule

// File: doc/trap_arbiter.md
TRAP_ARBITER -- requirements
Module: trap_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: if_exc_valid in 1, if_exc_cause in 5, if_exc_pc in 32, if_exc_va in 32; fetch-stage fault request.
REQ-004 SHALL have ports: ex_exc_valid in 1, ex_exc_cause in 5, ex_exc_pc in 32, ex_exc_inst in 32; illegal-instruction/ecall request.
REQ-005 SHALL have ports: mem_exc_valid in 1, mem_exc_cause in 5, mem_exc_pc in 32, mem_exc_va in 32, mem_exc_inst in 32; load/store fault request.
REQ-006 SHALL have ports: irq_pending in 3, already enable-masked; bit2 external, bit1 software, bit0 timer.
REQ-007 SHALL have ports: pipe_stall in 1 (pipeline frozen); csr_branch_signal in 1 (trap vector redirect taken).
REQ-008 SHALL have ports: trap_valid out 1, trap_id out 5, trap_pc out 32, trap_inst out 32, trap_va_imem out 32, trap_va_dmem out 32.
REQ-009 SHALL have ports: flush out 2 (2'b11 full flush, 2'b00 none), busy out 1, trap_err out 1, trap_count out 16.

Function
REQ-010 SHALL implement FSM states IDLE, TRAP, WAIT_REDIR.
REQ-011 In IDLE, winner selection SHALL be combinational; priority MEM > EX > IF > interrupts.
REQ-012 Interrupts SHALL be eligible only when no *_exc_valid is high and pipe_stall=0; among them external > software > timer.
REQ-013 Interrupt trap_id SHALL be {1'b1, code[3:0]}, codes ext=11, soft=3, timer=7; exception trap_id SHALL be {1'b0, cause[3:0]}.
REQ-014 On a winner in IDLE (cycle N), payload SHALL be registered and state SHALL move to TRAP at N+1.
REQ-015 Payload: trap_pc = winner pc (interrupt: if_exc_pc); trap_inst = ex/mem inst else 0; trap_va_imem = if_exc_va only for IF winner else 0; trap_va_dmem = mem_exc_va only for MEM winner else 0.
REQ-016 In TRAP, trap_valid SHALL be 1 for exactly one cycle, flush=2'b11, then state SHALL go to WAIT_REDIR.
REQ-017 In WAIT_REDIR, flush SHALL stay 2'b11 until csr_branch_signal=1; next cycle state=IDLE, flush=2'b00.
REQ-018 A 3-bit timeout counter SHALL clear on entering WAIT_REDIR; at 8 cycles without csr_branch_signal, trap_err SHALL set (sticky) and state SHALL return to IDLE.
REQ-019 Requests arriving while not IDLE SHALL be ignored, not queued.
REQ-020 csr_branch_signal in IDLE or TRAP SHALL have no effect.
REQ-021 busy SHALL be 1 in TRAP and WAIT_REDIR, 0 in IDLE.
REQ-022 trap_count SHALL increment once per trap_valid pulse and saturate at 16'hFFFF.
REQ-023 Outside TRAP, trap_valid SHALL be 0; payload outputs SHALL hold last registered values.

Reset
REQ-024 With rst=1 at a clock edge, state SHALL become IDLE and all outputs SHALL be 0, including trap_err and trap_count.
REQ-025 rst SHALL override every state, including mid-TRAP and mid-WAIT_REDIR; no trap_valid pulse on the reset cycle or the cycle after.

Verification
REQ-026 Single MEM fault, cause 5, pc 0x100, va 0xDEAD0000: trap_valid one cycle later, trap_id 0x05, trap_va_dmem 0xDEAD0000, flush 11 until branch ack, trap_count 1.
REQ-027 Simultaneous IF (cause 12), EX (cause 2), MEM (cause 7): trap_id 0x07 and trap_pc = mem_exc_pc; the IF and EX requests are dropped.
REQ-028 irq_pending=3'b011 with no exceptions, pipe_stall=0: trap_id 0x13; with pipe_stall=1 no trap until the stall drops.
REQ-029 No csr_branch_signal for 8 cycles in WAIT_REDIR: trap_err=1, busy=0, flush=00, and trap_err stays set on later traps.
REQ-030 rst asserted in WAIT_REDIR: next cycle flush=00, busy=0, trap_count=0.
REQ-031 Force trap_count to 0xFFFF and trigger a trap: trap_count stays 0xFFFF.
